// File: rtl/spi_xfer_pkg.sv
// Shared types and register map for the SPI burst sequencer.
package spi_xfer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CFG_DIV,
        ST_CFG_SS,
        ST_WR_TX,
        ST_WR_CTRL,
        ST_WAIT,
        ST_RD_RX,
        ST_RSP,
        ST_CLR_SS
    } state_e;

    localparam int SPI_SS_NB = 8;

    localparam logic [7:0] ADDR_TXRX0   = 8'h00;
    localparam logic [7:0] ADDR_CTRL    = 8'h10;
    localparam logic [7:0] ADDR_DIVIDER = 8'h14;
    localparam logic [7:0] ADDR_SS      = 8'h18;

    localparam int CTRL_ASS    = 13;
    localparam int CTRL_IE     = 12;
    localparam int CTRL_LSB    = 11;
    localparam int CTRL_TX_NEG = 10;
    localparam int CTRL_RX_NEG = 9;
    localparam int CTRL_GO     = 8;

    // Interrupt-driven, MSB-first, launch on falling edge, manual slave select.
    function automatic logic [31:0] ctrl_word(input int char_len);
        logic [31:0] w;
        w              = '0;
        w[CTRL_ASS]    = 1'b0;
        w[CTRL_IE]     = 1'b1;
        w[CTRL_LSB]    = 1'b0;
        w[CTRL_TX_NEG] = 1'b1;
        w[CTRL_RX_NEG] = 1'b0;
        w[CTRL_GO]     = 1'b1;
        w[6:0]         = char_len[6:0];
        return w;
    endfunction

endpackage

// File: rtl/spi_xfer_seq.sv
// Autonomous register-bus master for the SPI host core: turns a stream of
// transmit words into configured SPI transfers and returns the received words.
module spi_xfer_seq
    import spi_xfer_pkg::*;
#(
    parameter int CharLen       = 32,
    parameter int TimeoutCycles = 65535
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [15:0]          divider_i,
    input  logic [SPI_SS_NB-1:0] ss_sel_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [31:0]          cmd_data_i,
    input  logic                 cmd_last_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_data_o,
    output logic                 rsp_err_o,
    output logic                 re_o,
    output logic                 we_o,
    output logic [7:0]           addr_o,
    output logic [31:0]          wdata_o,
    output logic [3:0]           be_o,
    input  logic [31:0]          rdata_i,
    input  logic                 error_i,
    input  logic                 intr_i,
    output logic                 busy_o
);

    localparam int              CntW       = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] TimeoutVal = CntW'(TimeoutCycles);
    localparam logic [CntW-1:0] CntMax     = '1;
    localparam logic [31:0]     CtrlVal    = ctrl_word(CharLen);

    state_e          state;
    logic [CntW-1:0] cnt;
    logic            last_q;
    logic            err_q;
    logic            we_q;
    logic            re_q;
    logic [7:0]      addr_q;
    logic [31:0]     wdata_q;
    logic            cmd_ready_q;
    logic            rsp_valid_q;
    logic [31:0]     rsp_data_q;

    logic tx_fire;
    logic strobe_err;
    logic timeout;
    logic abort;

    // The TXRX0 write must carry the word in its handshake cycle, so only that
    // path bypasses the registered strobe/address/data.
    assign tx_fire = cmd_ready_q & cmd_valid_i;
    assign we_o    = we_q | tx_fire;
    assign re_o    = re_q;
    assign addr_o  = cmd_ready_q ? ADDR_TXRX0 : addr_q;
    assign wdata_o = cmd_ready_q ? cmd_data_i : wdata_q;
    assign be_o    = 4'hF;

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = (state != ST_IDLE);

    // A failed slave-select release is harmless, so CLR_SS never aborts.
    assign strobe_err = error_i & (we_o | re_o) & (state != ST_CLR_SS);
    assign timeout    = (state == ST_WAIT) & ~intr_i & (cnt == TimeoutVal);
    assign abort      = strobe_err | timeout;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            we_q <= 1'b0;
            re_q <= 1'b0;
            if (abort) begin
                err_q       <= 1'b1;
                last_q      <= 1'b1;
                cmd_ready_q <= 1'b0;
                rsp_data_q  <= '0;
                rsp_valid_q <= 1'b1;
                state       <= ST_RSP;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_valid_i) begin
                            state   <= ST_CFG_DIV;
                            we_q    <= 1'b1;
                            addr_q  <= ADDR_DIVIDER;
                            wdata_q <= 32'(divider_i);
                        end
                    end
                    ST_CFG_DIV: begin
                        state   <= ST_CFG_SS;
                        we_q    <= 1'b1;
                        addr_q  <= ADDR_SS;
                        wdata_q <= 32'(ss_sel_i);
                    end
                    ST_CFG_SS: begin
                        state       <= ST_WR_TX;
                        cmd_ready_q <= 1'b1;
                    end
                    ST_WR_TX: begin
                        if (cmd_valid_i) begin
                            cmd_ready_q <= 1'b0;
                            last_q      <= cmd_last_i;
                            state       <= ST_WR_CTRL;
                            we_q        <= 1'b1;
                            addr_q      <= ADDR_CTRL;
                            wdata_q     <= CtrlVal;
                        end
                    end
                    ST_WR_CTRL: begin
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (cnt != CntMax) begin
                            cnt <= cnt + CntW'(1);
                        end
                        if (intr_i) begin
                            state  <= ST_RD_RX;
                            re_q   <= 1'b1;
                            addr_q <= ADDR_TXRX0;
                        end
                    end
                    ST_RD_RX: begin
                        rsp_data_q  <= rdata_i;
                        rsp_valid_q <= 1'b1;
                        state       <= ST_RSP;
                    end
                    ST_RSP: begin
                        if (rsp_ready_i) begin
                            rsp_valid_q <= 1'b0;
                            err_q       <= 1'b0;
                            if (last_q) begin
                                state   <= ST_CLR_SS;
                                we_q    <= 1'b1;
                                addr_q  <= ADDR_SS;
                                wdata_q <= '0;
                            end else begin
                                state       <= ST_WR_TX;
                                cmd_ready_q <= 1'b1;
                            end
                        end
                    end
                    ST_CLR_SS: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_xfer_seq.sv
// Self-checking bench for spi_xfer_seq with a loopback SPI core model.
module tb_spi_xfer_seq;

    localparam logic [7:0]  A_TX   = 8'h00;
    localparam logic [7:0]  A_CTRL = 8'h10;
    localparam logic [7:0]  A_DIV  = 8'h14;
    localparam logic [7:0]  A_SS   = 8'h18;
    // IE | TX_NEG | GO | 32-bit character
    localparam logic [31:0] CTRL_EXP = (32'd1 << 12) | (32'd1 << 10) | (32'd1 << 8) | 32'd32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] divider;
    logic [7:0]  ss_sel;
    logic        cmd_valid, cmd_ready, cmd_last;
    logic [31:0] cmd_data;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_data;
    logic        re, we;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata;
    logic [3:0]  be;
    logic        error, intr, busy;

    typedef struct packed { logic [31:0] data; logic last; } cmd_t;
    typedef struct packed { logic rd; logic [7:0] addr; logic [31:0] data; } bus_t;
    typedef struct packed { logic [31:0] data; logic err; } rsp_t;

    cmd_t cmd_q[$];
    bus_t log_q[$], exp_log[$];
    rsp_t rsp_q[$], exp_rsp[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          countdown = -1;
    logic        stuck = 1'b0;
    logic        rsp_hold = 1'b0;
    logic        err_arm = 1'b0;
    logic [7:0]  err_addr = 8'h00;
    logic [31:0] tx_reg = '0;

    spi_xfer_seq #(.CharLen(32), .TimeoutCycles(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .divider_i(divider), .ss_sel_i(ss_sel),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_data_i(cmd_data), .cmd_last_i(cmd_last),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
        .re_o(re), .we_o(we), .addr_o(addr), .wdata_o(wdata), .be_o(be),
        .rdata_i(rdata), .error_i(error), .intr_i(intr), .busy_o(busy)
    );

    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    // Command source: presents the queue head, pops on handshake.
    initial begin
        bit hs;
        cmd_valid = 1'b0; cmd_data = '0; cmd_last = 1'b0;
        forever begin
            @(negedge clk);
            hs = cmd_valid && cmd_ready;
            @(posedge clk);
            if (hs && cmd_q.size() > 0) void'(cmd_q.pop_front());
            #1;
            if (cmd_q.size() > 0) begin
                cmd_valid = 1'b1; cmd_data = cmd_q[0].data; cmd_last = cmd_q[0].last;
            end else begin
                cmd_valid = 1'b0; cmd_data = $urandom; cmd_last = 1'b0;
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            rsp_ready = !rsp_hold && ($urandom_range(0, 3) != 0);
        end
    end

    // One-shot bus error on the armed register address.
    initial begin
        error = 1'b0;
        forever begin
            @(posedge clk); #2;
            error = 1'b0;
            if (err_arm && (we || re) && addr == err_addr) begin
                error = 1'b1;
                err_arm = 1'b0;
            end
        end
    end

    // Loopback core model and bus/response monitors.
    initial begin
        intr = 1'b0; rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                intr = 1'b0; countdown = -1;
            end else begin
                if (countdown > 0) countdown--;
                else if (countdown == 0) begin intr = 1'b1; countdown = -1; end
                if (we || re) begin
                    bus_t e;
                    n_cmp++;
                    if (we && re) begin
                        n_bad++;
                        $display("FAIL strobe_excl: re=%b we=%b, required never both", re, we);
                    end
                    e = {re, addr, re ? 32'h0 : wdata};
                    log_q.push_back(e);
                    if (!error) begin
                        if (we && addr == A_TX) begin tx_reg = wdata; rdata = wdata; end
                        if (we && addr == A_CTRL && wdata[8] && !stuck) countdown = $urandom_range(1, 6);
                        if (re && addr == A_TX) intr = 1'b0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
            rsp_t r;
            r = {rsp_data, rsp_err};
            rsp_q.push_back(r);
        end
    end

    task automatic clear_logs();
        log_q.delete(); exp_log.delete(); rsp_q.delete(); exp_rsp.delete();
    endtask

    task automatic push_word(input logic [31:0] d, input logic last);
        cmd_t c;
        c = {d, last};
        cmd_q.push_back(c);
    endtask

    task automatic exp_w(input logic [7:0] a, input logic [31:0] d);
        bus_t e;
        e = {1'b0, a, d};
        exp_log.push_back(e);
    endtask

    task automatic exp_word(input logic [31:0] w);
        bus_t e;
        rsp_t r;
        exp_w(A_TX, w);
        exp_w(A_CTRL, CTRL_EXP);
        e = {1'b1, A_TX, 32'h0};
        exp_log.push_back(e);
        r = {w, 1'b0};
        exp_rsp.push_back(r);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        repeat (2) @(negedge clk);
        while ((cmd_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk); n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_bad++;
            $display("FAIL idle_wait: busy=%b pending=%0d after %0d cycles, required idle", busy, cmd_q.size(), n);
        end
    endtask

    task automatic wait_ctrl_write(input int budget);
        int n = 0;
        @(negedge clk);
        while (!(we && addr == A_CTRL) && n < budget) begin @(negedge clk); n++; end
        n_cmp++;
        if (n >= budget) begin n_bad++; $display("FAIL ctrl_wait: no CTRL write within %0d cycles", budget); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; divider = '0; ss_sel = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp += 10;
        if (we !== 1'b0)        begin n_bad++; $display("FAIL rst_we: got %b required 0", we); end
        if (re !== 1'b0)        begin n_bad++; $display("FAIL rst_re: got %b required 0", re); end
        if (addr !== 8'h0)      begin n_bad++; $display("FAIL rst_addr: got %h required 0", addr); end
        if (wdata !== 32'h0)    begin n_bad++; $display("FAIL rst_wdata: got %h required 0", wdata); end
        if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_ready: got %b required 0", cmd_ready); end
        if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        if (rsp_data !== 32'h0) begin n_bad++; $display("FAIL rst_rsp_data: got %h required 0", rsp_data); end
        if (rsp_err !== 1'b0)   begin n_bad++; $display("FAIL rst_rsp_err: got %b required 0", rsp_err); end
        if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (be !== 4'hF)        begin n_bad++; $display("FAIL rst_be: got %h required f", be); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_single();
        clear_logs();
        divider = 16'd4; ss_sel = 8'd1;
        exp_w(A_DIV, 32'd4); exp_w(A_SS, 32'd1); exp_word(32'hA5A5_1234); exp_w(A_SS, 32'd0);
        push_word(32'hA5A5_1234, 1'b1);
        wait_idle(300);
        n_cmp++;
        if (log_q.size() != exp_log.size()) begin n_bad++; $display("FAIL single_log_len: got %0d required %0d", log_q.size(), exp_log.size()); end
        foreach (exp_log[i]) if (i < log_q.size()) begin
            n_cmp++;
            if (log_q[i] !== exp_log[i]) begin n_bad++; $display("FAIL single_log[%0d]: got %h required %h", i, log_q[i], exp_log[i]); end
        end
        n_cmp++;
        if (rsp_q.size() != 1) begin n_bad++; $display("FAIL single_rsp_len: got %0d required 1", rsp_q.size()); end
        else begin
            n_cmp++;
            if (rsp_q[0] !== exp_rsp[0]) begin n_bad++; $display("FAIL single_rsp: got %h required %h", rsp_q[0], exp_rsp[0]); end
        end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL single_busy: got %b required 0", busy); end
    endtask

    task automatic test_burst();
        for (int b = 0; b < 4; b++) begin
            int n;
            logic [31:0] w;
            clear_logs();
            n = $urandom_range(2, 5);
            divider = 16'($urandom); ss_sel = 8'($urandom);
            exp_w(A_DIV, 32'(divider)); exp_w(A_SS, 32'(ss_sel));
            for (int k = 0; k < n; k++) begin
                w = $urandom;
                exp_word(w);
                push_word(w, k == n - 1);
            end
            exp_w(A_SS, 32'd0);
            wait_idle(600);
            n_cmp++;
            if (log_q.size() != exp_log.size()) begin n_bad++; $display("FAIL burst%0d_log_len: got %0d required %0d", b, log_q.size(), exp_log.size()); end
            foreach (exp_log[i]) if (i < log_q.size()) begin
                n_cmp++;
                if (log_q[i] !== exp_log[i]) begin n_bad++; $display("FAIL burst%0d_log[%0d]: got %h required %h", b, i, log_q[i], exp_log[i]); end
            end
            n_cmp++;
            if (rsp_q.size() != exp_rsp.size()) begin n_bad++; $display("FAIL burst%0d_rsp_len: got %0d required %0d", b, rsp_q.size(), exp_rsp.size()); end
            foreach (exp_rsp[i]) if (i < rsp_q.size()) begin
                n_cmp++;
                if (rsp_q[i] !== exp_rsp[i]) begin n_bad++; $display("FAIL burst%0d_rsp[%0d]: got %h required %h", b, i, rsp_q[i], exp_rsp[i]); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] w0, w1;
        int n = 0;
        clear_logs();
        w0 = $urandom; w1 = $urandom;
        divider = 16'($urandom); ss_sel = 8'($urandom);
        exp_w(A_DIV, 32'(divider)); exp_w(A_SS, 32'(ss_sel));
        exp_word(w0); exp_word(w1); exp_w(A_SS, 32'd0);
        rsp_hold = 1'b1;
        push_word(w0, 1'b0); push_word(w1, 1'b1);
        @(negedge clk);
        while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
        n_cmp++;
        if (n >= 200) begin n_bad++; $display("FAIL bp_rsp_wait: no response within 200 cycles"); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp += 3;
            if (rsp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b required 1", k, rsp_valid); end
            if (rsp_data !== w0)    begin n_bad++; $display("FAIL bp_data[%0d]: got %h required %h", k, rsp_data, w0); end
            if (we !== 1'b0)        begin n_bad++; $display("FAIL bp_no_write[%0d]: we=%b required 0", k, we); end
        end
        rsp_hold = 1'b0;
        wait_idle(400);
        n_cmp++;
        if (log_q.size() != exp_log.size()) begin n_bad++; $display("FAIL bp_log_len: got %0d required %0d", log_q.size(), exp_log.size()); end
        foreach (exp_log[i]) if (i < log_q.size()) begin
            n_cmp++;
            if (log_q[i] !== exp_log[i]) begin n_bad++; $display("FAIL bp_log[%0d]: got %h required %h", i, log_q[i], exp_log[i]); end
        end
        n_cmp++;
        if (rsp_q.size() != 2) begin n_bad++; $display("FAIL bp_rsp_len: got %0d required 2", rsp_q.size()); end
        foreach (exp_rsp[i]) if (i < rsp_q.size()) begin
            n_cmp++;
            if (rsp_q[i] !== exp_rsp[i]) begin n_bad++; $display("FAIL bp_rsp[%0d]: got %h required %h", i, rsp_q[i], exp_rsp[i]); end
        end
    endtask

    task automatic test_timeout();
        int t0, n = 0;
        logic [31:0] w;
        rsp_t r;
        clear_logs();
        stuck = 1'b1;
        w = $urandom;
        divider = 16'd7; ss_sel = 8'h80;
        exp_w(A_DIV, 32'd7); exp_w(A_SS, 32'h80); exp_w(A_TX, w); exp_w(A_CTRL, CTRL_EXP); exp_w(A_SS, 32'd0);
        r = {32'h0, 1'b1};
        exp_rsp.push_back(r);
        push_word(w, 1'b1);
        wait_ctrl_write(50);
        t0 = cyc;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        n_cmp++;
        if (cyc - t0 - 1 != 17) begin n_bad++; $display("FAIL to_wait_cycles: got %0d required 17", cyc - t0 - 1); end
        wait_idle(200);
        stuck = 1'b0;
        n_cmp++;
        if (log_q.size() != exp_log.size()) begin n_bad++; $display("FAIL to_log_len: got %0d required %0d", log_q.size(), exp_log.size()); end
        foreach (exp_log[i]) if (i < log_q.size()) begin
            n_cmp++;
            if (log_q[i] !== exp_log[i]) begin n_bad++; $display("FAIL to_log[%0d]: got %h required %h", i, log_q[i], exp_log[i]); end
        end
        n_cmp++;
        if (rsp_q.size() != 1) begin n_bad++; $display("FAIL to_rsp_len: got %0d required 1", rsp_q.size()); end
        else begin
            n_cmp++;
            if (rsp_q[0] !== exp_rsp[0]) begin n_bad++; $display("FAIL to_rsp: got %h required %h", rsp_q[0], exp_rsp[0]); end
        end
    endtask

    task automatic test_bus_error();
        logic [31:0] w0, w1;
        rsp_t r;
        clear_logs();
        w0 = $urandom; w1 = $urandom;
        divider = 16'($urandom); ss_sel = 8'($urandom);
        exp_w(A_DIV, 32'(divider)); exp_w(A_SS, 32'(ss_sel));
        exp_w(A_TX, w0); exp_w(A_CTRL, CTRL_EXP); exp_w(A_SS, 32'd0);
        r = {32'h0, 1'b1};
        exp_rsp.push_back(r);
        exp_w(A_DIV, 32'(divider)); exp_w(A_SS, 32'(ss_sel));
        exp_word(w1); exp_w(A_SS, 32'd0);
        err_addr = A_CTRL; err_arm = 1'b1;
        push_word(w0, 1'b0); push_word(w1, 1'b1);
        wait_idle(500);
        n_cmp++;
        if (log_q.size() != exp_log.size()) begin n_bad++; $display("FAIL berr_log_len: got %0d required %0d", log_q.size(), exp_log.size()); end
        foreach (exp_log[i]) if (i < log_q.size()) begin
            n_cmp++;
            if (log_q[i] !== exp_log[i]) begin n_bad++; $display("FAIL berr_log[%0d]: got %h required %h", i, log_q[i], exp_log[i]); end
        end
        n_cmp++;
        if (rsp_q.size() != 2) begin n_bad++; $display("FAIL berr_rsp_len: got %0d required 2", rsp_q.size()); end
        else begin
            n_cmp += 2;
            if (rsp_q[0].err !== 1'b1) begin n_bad++; $display("FAIL berr_rsp0_err: got %b required 1", rsp_q[0].err); end
            if (rsp_q[1] !== exp_rsp[1]) begin n_bad++; $display("FAIL berr_rsp1: got %h required %h", rsp_q[1], exp_rsp[1]); end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] w;
        clear_logs();
        stuck = 1'b1;
        divider = 16'd3; ss_sel = 8'd2;
        push_word($urandom, 1'b1);
        wait_ctrl_write(50);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_cmp++;
        if ({we, re, addr, wdata, cmd_ready, rsp_valid, rsp_data, rsp_err, busy} !== '0) begin
            n_bad++;
            $display("FAIL rmw_outputs: we=%b re=%b addr=%h wdata=%h rdy=%b rv=%b rd=%h re=%b busy=%b, required all 0",
                     we, re, addr, wdata, cmd_ready, rsp_valid, rsp_data, rsp_err, busy);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if (we || re || busy) begin n_bad++; $display("FAIL rmw_quiet[%0d]: we=%b re=%b busy=%b required 0", k, we, re, busy); end
        end
        stuck = 1'b0;
        clear_logs();
        w = $urandom;
        exp_w(A_DIV, 32'd3); exp_w(A_SS, 32'd2); exp_word(w); exp_w(A_SS, 32'd0);
        push_word(w, 1'b1);
        wait_idle(300);
        n_cmp++;
        if (log_q.size() != exp_log.size()) begin n_bad++; $display("FAIL rmw_log_len: got %0d required %0d", log_q.size(), exp_log.size()); end
        foreach (exp_log[i]) if (i < log_q.size()) begin
            n_cmp++;
            if (log_q[i] !== exp_log[i]) begin n_bad++; $display("FAIL rmw_log[%0d]: got %h required %h", i, log_q[i], exp_log[i]); end
        end
        n_cmp++;
        if (rsp_q.size() != 1) begin n_bad++; $display("FAIL rmw_rsp_len: got %0d required 1", rsp_q.size()); end
        else begin
            n_cmp++;
            if (rsp_q[0] !== exp_rsp[0]) begin n_bad++; $display("FAIL rmw_rsp: got %h required %h", rsp_q[0], exp_rsp[0]); end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_backpressure();
        test_timeout();
        test_bus_error();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
